// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_t;

    localparam int DEF_AW           = 16;
    localparam int DEF_DW           = 16;
    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_MAX_BURST    = 8;

endpackage

// File: rtl/dmem_arb_if.sv
// Bundles the CPU port, DMA port and memory-side signals of the arbiter.
interface dmem_arb_if
    import dmem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_last;
    logic          dma_gnt;
    logic [DW-1:0] dma_rdata;
    logic          dma_rvalid;

    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_read_data;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
        output dma_gnt, dma_rdata, dma_rvalid,
        output mem_address, mem_write_data, mem_read, mem_write,
        input  mem_read_data
    );

    // Requesters and memory side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  mem_address, mem_write_data, mem_read, mem_write,
        output mem_read_data
    );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != WIDTH'(LIMIT))) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority with bounded DMA starvation
// and locked DMA bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = DEF_AW,
    parameter int DW           = DEF_DW,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int MAX_BURST    = DEF_MAX_BURST
) (
    input  logic       clk,
    input  logic       rst,
    dmem_arb_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t    state;
    logic [BW-1:0] burst_cnt;
    logic [SW-1:0] starve_cnt;
    logic          cpu_grant;
    logic          dma_grant;
    logic          starve_full;
    logic          burst_end;
    logic          starve_inc;
    logic          starve_clr;

    assign starve_full = (starve_cnt == SW'(STARVE_LIMIT));
    assign burst_end   = bus.dma_last || (burst_cnt == BW'(MAX_BURST - 1));

    // Grants are suppressed while rst is high so no partial write lands on the reset edge.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (!rst) begin
            if (state == S_DMA) begin
                dma_grant = bus.dma_req;
            end else begin
                dma_grant = bus.dma_req && (!bus.cpu_req || starve_full);
                cpu_grant = bus.cpu_req && !dma_grant;
            end
        end
    end

    always_comb begin
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        if (cpu_grant) begin
            bus.mem_address    = bus.cpu_addr;
            bus.mem_write_data = bus.cpu_wdata;
            bus.mem_read       = !bus.cpu_we;
            bus.mem_write      = bus.cpu_we;
        end else if (dma_grant) begin
            bus.mem_address    = bus.dma_addr;
            bus.mem_write_data = bus.dma_wdata;
            bus.mem_read       = !bus.dma_we;
            bus.mem_write      = bus.dma_we;
        end
    end

    assign bus.cpu_stall = bus.cpu_req && !cpu_grant;
    assign bus.cpu_rdata = bus.mem_read_data;
    assign bus.dma_gnt   = dma_grant;

    // Starvation only accrues in CPU-priority mode while DMA is actually waiting.
    assign starve_inc = cpu_grant && bus.dma_req;
    assign starve_clr = (state == S_DMA) || dma_grant || !bus.dma_req;

    sat_counter #(
        .WIDTH (SW),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (starve_inc),
        .clr (starve_clr),
        .cnt (starve_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_CPU;
            burst_cnt      <= '0;
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= '0;
        end else begin
            bus.dma_rvalid <= dma_grant && !bus.dma_we;
            if (dma_grant && !bus.dma_we) begin
                bus.dma_rdata <= bus.mem_read_data;
            end
            case (state)
                S_CPU: begin
                    if (dma_grant && !bus.dma_last && (MAX_BURST > 1)) begin
                        state     <= S_DMA;
                        burst_cnt <= BW'(1);
                    end
                end
                S_DMA: begin
                    if (!bus.dma_req || burst_end) begin
                        state     <= S_CPU;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                default: begin
                    state     <= S_CPU;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a rule-level reference model.
module tb_dmem_arbiter;

    localparam int AW           = 16;
    localparam int DW           = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int MAX_BURST    = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_arb_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (STARVE_LIMIT),
        .MAX_BURST    (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory seen by the DUT: combinational read, write on rising edge.
    logic [DW-1:0] tb_mem [0:255] = '{default: '0};
    assign bus.mem_read_data = tb_mem[bus.mem_address[7:0]];
    always @(posedge clk) begin
        if (bus.mem_write) tb_mem[bus.mem_address[7:0]] <= bus.mem_write_data;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:255] = '{default: '0};
    bit            m_burst;
    int            m_starve;
    int            m_beats;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          exp_cg, exp_dg;

    logic          obs_dg, obs_cg, obs_mw, obs_rv;
    logic [DW-1:0] obs_crd, obs_rd;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the rules, compare at negedge, advance model at posedge.
    task automatic cycle();
        logic          cg, dg;
        logic [AW-1:0] ea;
        if (rst) begin
            cg = 1'b0; dg = 1'b0;
        end else if (m_burst) begin
            dg = bus.dma_req; cg = 1'b0;
        end else begin
            dg = bus.dma_req && (!bus.cpu_req || m_starve == STARVE_LIMIT);
            cg = bus.cpu_req && !dg;
        end
        exp_cg = cg;
        exp_dg = dg;
        ea = cg ? bus.cpu_addr : (dg ? bus.dma_addr : '0);

        @(negedge clk);
        obs_dg  = bus.dma_gnt;
        obs_cg  = bus.cpu_req && !bus.cpu_stall;
        obs_mw  = bus.mem_write;
        obs_crd = bus.cpu_rdata;
        obs_rv  = bus.dma_rvalid;
        obs_rd  = bus.dma_rdata;

        check("dma_gnt",   bus.dma_gnt,   dg);
        check("cpu_stall", bus.cpu_stall, bus.cpu_req && !cg);
        check("mem_read",  bus.mem_read,  (cg && !bus.cpu_we) || (dg && !bus.dma_we));
        check("mem_write", bus.mem_write, (cg && bus.cpu_we) || (dg && bus.dma_we));
        check("mem_addr",  bus.mem_address, ea);
        if (cg || dg)
            check("mem_wdata", bus.mem_write_data, cg ? bus.cpu_wdata : bus.dma_wdata);
        if (cg && !bus.cpu_we)
            check("cpu_rdata", bus.cpu_rdata, ref_mem[bus.cpu_addr[7:0]]);
        check("dma_rvalid", bus.dma_rvalid, rst ? 1'b0 : m_rvalid);
        check("dma_rdata",  bus.dma_rdata,  rst ? '0 : m_rdata);

        @(posedge clk);
        if (rst) begin
            m_burst = 0; m_starve = 0; m_beats = 0; m_rvalid = 1'b0; m_rdata = '0;
        end else begin
            m_rvalid = dg && !bus.dma_we;
            if (m_rvalid) m_rdata = ref_mem[bus.dma_addr[7:0]];
            if (cg && bus.cpu_we) ref_mem[bus.cpu_addr[7:0]] = bus.cpu_wdata;
            if (dg && bus.dma_we) ref_mem[bus.dma_addr[7:0]] = bus.dma_wdata;
            if (m_burst || dg || !bus.dma_req) m_starve = 0;
            else if (cg && m_starve < STARVE_LIMIT) m_starve++;
            if (!m_burst) begin
                if (dg && !bus.dma_last && MAX_BURST > 1) begin
                    m_burst = 1; m_beats = 1;
                end
            end else if (!bus.dma_req || bus.dma_last || m_beats + 1 >= MAX_BURST) begin
                m_burst = 0; m_beats = 0;
            end else begin
                m_beats++;
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        bus.dma_last = 1'b0;
        cycle();
    endtask

    initial begin
        int beats;
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.dma_last = 1'b0;
        m_burst = 0; m_starve = 0; m_beats = 0; m_rvalid = 1'b0; m_rdata = '0;

        // Reset state: stall mirrors cpu_req, no memory activity.
        cycle();
        check("rst_stall", obs_cg, 1'b0);
        rst = 1'b0;
        idle();

        // CPU write then read of address 5.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'd5; bus.cpu_wdata = 16'hBEEF;
        cycle();
        check("t1_mem_write", obs_mw, 1'b1);
        bus.cpu_we = 1'b0;
        cycle();
        check("t1_rdata", obs_crd, 16'hBEEF);
        check("t1_granted", obs_cg, 1'b1);

        // DMA single-beat read of address 3, then CPU overwrites it the next cycle.
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'd3; bus.cpu_wdata = 16'h1234;
        cycle();
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'd3; bus.dma_last = 1'b1;
        cycle();
        check("t2_gnt", obs_dg, 1'b1);
        bus.dma_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'd3; bus.cpu_wdata = 16'h5555;
        cycle();
        check("t2_rvalid", obs_rv, 1'b1);
        check("t2_rdata", obs_rd, 16'h1234);
        idle();

        // Both requesting continuously with single DMA beats: 4 CPU then 1 DMA.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd5;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'd3; bus.dma_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("t3_pattern", obs_dg, (i % 5) == 4);
        end
        idle();

        // Three-beat write burst forced in after starvation; CPU resumes afterwards.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd5;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'd40; bus.dma_wdata = 16'hA000;
        beats = 0;
        for (int i = 0; i < 8; i++) begin
            bus.dma_last = (beats == 2);
            cycle();
            check("t4_pattern", obs_dg, (i >= 4) && (i <= 6));
            if (obs_dg) begin
                beats++;
                bus.dma_addr  = bus.dma_addr + 16'd1;
                bus.dma_wdata = bus.dma_wdata + 16'd1;
                if (beats == 3) bus.dma_req = 1'b0;
            end
        end
        idle();

        // Burst without dma_last is cut at MAX_BURST beats, then starvation rebuilds.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd41;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'd50; bus.dma_wdata = 16'hB000;
        bus.dma_last = 1'b0;
        for (int i = 0; i < 17; i++) begin
            cycle();
            check("t5_pattern", obs_dg, ((i >= 4) && (i <= 11)) || (i == 16));
            if (obs_dg) begin
                bus.dma_addr  = bus.dma_addr + 16'd1;
                bus.dma_wdata = bus.dma_wdata + 16'd1;
            end
        end
        idle();

        // Reset during beat 2 of a write burst.
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'd20; bus.dma_wdata = 16'hAAAA;
        bus.dma_last = 1'b0;
        cycle();
        check("t6_beat1", obs_dg, 1'b1);
        bus.dma_addr = 16'd21; bus.dma_wdata = 16'hBBBB;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd20;
        #2 rst = 1'b1;
        cycle();
        check("t6_mw_in_rst", obs_mw, 1'b0);
        check("t6_rv_in_rst", obs_rv, 1'b0);
        rst = 1'b0;
        check("t6_no_partial", tb_mem[21], 16'h0000);
        cycle();
        check("t6_cpu_first", obs_cg, 1'b1);
        idle();

        // Randomized traffic; requesters hold their request until granted.
        for (int i = 0; i < 400; i++) begin
            if (!(bus.cpu_req && !exp_cg)) begin
                bus.cpu_req   = ($urandom_range(0, 9) < 6);
                bus.cpu_we    = $urandom_range(0, 1);
                bus.cpu_addr  = AW'($urandom_range(0, 15));
                bus.cpu_wdata = DW'($urandom);
            end
            if (!(bus.dma_req && !exp_dg)) begin
                bus.dma_req   = ($urandom_range(0, 9) < 6);
                bus.dma_we    = $urandom_range(0, 1);
                bus.dma_addr  = AW'($urandom_range(0, 15));
                bus.dma_wdata = DW'($urandom);
                bus.dma_last  = ($urandom_range(0, 3) == 0);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
